multicycle_ctrl_fsm: RTL and testbench

//  Control FSM that sequences the RV32I datapath over several cycles:

---
 rtl/multicycle_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Sequences an RV32I datapath over FETCH / DECODE / EXEC / MEM / WB.
//   Drives the immediate-format select, the ALU operand muxes, PC update,
//   register write and the memory request/ready handshake. Traps on an
//   illegal opcode or when a memory request waits too long.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   0     | FETCH  : request instruction word, load IR on mem_ready
//   1     | DECODE : latch opcode/rd, check opcode legality
//   2     | EXEC   : drive ALU operands; branches retire here
//   3     | MEM    : load/store access, held until mem_ready
//   4     | WB     : register write-back and PC update, retire
//   7     | TRAP   : sticky fault, all strobes low until reset
//
// Parameters
//   MEM_TIMEOUT  max wait cycles for mem_ready per request (0 = never)
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   instr[31:0]         instruction register contents, used in DECODE
//   mem_ready           memory completes the current request this cycle
//   br_taken            branch comparator result, valid in EXEC
//   state[2:0]          current FSM state (encoding above)
//   mem_req, mem_we     memory request / store qualifier
//   ir_we, pc_we        instruction register / PC load strobes
//   pc_sel[1:0]         0 pc+4, 1 pc+imm, 2 alu_result & ~1
//   imm_sel[2:0]        0 none, 1 I, 2 S, 3 B, 4 U, 5 J
//   alu_src_a[1:0]      0 rs1, 1 pc, 2 zero
//   alu_src_b           0 rs2, 1 imm
//   reg_we              register file write (never for rd == x0)
//   wb_sel[1:0]         0 alu, 1 mem rdata, 2 pc+4
//   instr_done          one-cycle pulse on the retiring cycle
//   trap                sticky fault flag
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        instr_done,
    output logic        trap
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t         state_q, state_d;
    logic [6:0]     op_q;
    logic [4:0]     rd_q;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_inc;
    logic           waiting, timeout;

    logic mem_req_raw, mem_we_raw, ir_we_raw, pc_we_raw, reg_we_raw, done_raw;
    logic [2:0] dec_imm;
    logic [1:0] dec_a;
    logic       dec_b;

    logic unused_instr_hi;
    assign unused_instr_hi = ^instr[31:12];

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    // Operand/immediate controls depend only on the latched opcode, so the
    // same values are held through EXEC, MEM and WB (MEM needs the address
    // path stable until mem_ready; WB needs imm J/I for the PC target).
    always_comb begin
        dec_imm = 3'd0;
        dec_a   = 2'd0;
        dec_b   = 1'b0;
        case (op_q)
            OP_I, OP_LOAD, OP_JALR: begin dec_imm = 3'd1; dec_b = 1'b1; end
            OP_STORE:               begin dec_imm = 3'd2; dec_b = 1'b1; end
            OP_BRANCH:              begin dec_imm = 3'd3; end
            OP_LUI:                 begin dec_imm = 3'd4; dec_a = 2'd2; dec_b = 1'b1; end
            OP_AUIPC:               begin dec_imm = 3'd4; dec_a = 2'd1; dec_b = 1'b1; end
            OP_JAL:                 begin dec_imm = 3'd5; dec_a = 2'd1; dec_b = 1'b1; end
            default:                begin dec_imm = 3'd0; end
        endcase
    end

    // Timeout fires on the wait cycle that brings the count to MEM_TIMEOUT;
    // a mem_ready in that same cycle takes priority.
    assign waiting      = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign wait_cnt_inc = wait_cnt_q + 1'b1;
    assign timeout      = (MEM_TIMEOUT != 0) && waiting && (wait_cnt_inc == CW'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            op_q       <= 7'd0;
            rd_q       <= 5'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                wait_cnt_q <= '0;
            else if (waiting)
                wait_cnt_q <= wait_cnt_inc;
            if (state_q == S_DECODE) begin
                op_q <= instr[6:0];
                rd_q <= instr[11:7];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_raw = 1'b0;
        mem_we_raw  = 1'b0;
        ir_we_raw   = 1'b0;
        pc_we_raw   = 1'b0;
        reg_we_raw  = 1'b0;
        done_raw    = 1'b0;
        pc_sel      = 2'd0;
        imm_sel     = 3'd0;
        alu_src_a   = 2'd0;
        alu_src_b   = 1'b0;
        wb_sel      = 2'd0;
        trap        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_raw = 1'b1;
                if (mem_ready) begin
                    ir_we_raw = 1'b1;
                    state_d   = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                state_d = is_legal(instr[6:0]) ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                imm_sel   = dec_imm;
                alu_src_a = dec_a;
                alu_src_b = dec_b;
                case (op_q)
                    OP_BRANCH: begin
                        pc_we_raw = 1'b1;
                        pc_sel    = br_taken ? 2'd1 : 2'd0;
                        done_raw  = 1'b1;
                        state_d   = S_FETCH;
                    end
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                imm_sel     = dec_imm;
                alu_src_a   = dec_a;
                alu_src_b   = dec_b;
                mem_req_raw = 1'b1;
                mem_we_raw  = (op_q == OP_STORE);
                if (mem_ready) begin
                    if (op_q == OP_STORE) begin
                        pc_we_raw = 1'b1;
                        done_raw  = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                imm_sel    = dec_imm;
                alu_src_a  = dec_a;
                alu_src_b  = dec_b;
                reg_we_raw = (rd_q != 5'd0);
                pc_we_raw  = 1'b1;
                done_raw   = 1'b1;
                state_d    = S_FETCH;
                case (op_q)
                    OP_LOAD: wb_sel = 2'd1;
                    OP_JAL:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
                    OP_JALR: begin wb_sel = 2'd2; pc_sel = 2'd2; end
                    default: wb_sel = 2'd0;
                endcase
            end
            S_TRAP: begin
                trap    = 1'b1;
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // State is already FETCH while reset is high, so the FETCH request has to
    // be masked here to keep every strobe quiet until reset is released.
    assign state      = state_q;
    assign mem_req    = mem_req_raw & ~reset;
    assign mem_we     = mem_we_raw  & ~reset;
    assign ir_we      = ir_we_raw   & ~reset;
    assign pc_we      = pc_we_raw   & ~reset;
    assign reg_we     = reg_we_raw  & ~reset;
    assign instr_done = done_raw    & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq;
        logic       mwe;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcsel;
        logic [2:0] imm;
        logic [1:0] a;
        logic       b;
        logic       rwe;
        logic [1:0] wbsel;
        logic       done;
        logic       trap;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        mem_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [2:0]  state;
    logic        mem_req, mem_we, ir_we, pc_we, alu_src_b, reg_we, instr_done, trap;
    logic [1:0]  pc_sel, alu_src_a, wb_sel;
    logic [2:0]  imm_sel;

    vec_t  exp_q[$];
    string nm_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
        .br_taken(br_taken), .state(state), .mem_req(mem_req), .mem_we(mem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_we(reg_we),
        .wb_sel(wb_sel), .instr_done(instr_done), .trap(trap)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] st, input logic mreq, input logic mwe,
                                input logic irwe, input logic pcwe, input logic [1:0] pcsel,
                                input logic [2:0] imm, input logic [1:0] a, input logic b,
                                input logic rwe, input logic [1:0] wbsel, input logic done,
                                input logic trp);
        vec_t v;
        v.st = st; v.mreq = mreq; v.mwe = mwe; v.irwe = irwe; v.pcwe = pcwe;
        v.pcsel = pcsel; v.imm = imm; v.a = a; v.b = b; v.rwe = rwe;
        v.wbsel = wbsel; v.done = done; v.trap = trp;
        return v;
    endfunction

    // Monitor: every cycle with a pending expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t  e, act;
            string nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            act = {state, mem_req, mem_we, ir_we, pc_we, pc_sel, imm_sel,
                   alu_src_a, alu_src_b, reg_we, wb_sel, instr_done, trap};
            n_vec++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, act, e);
            end
        end
    end

    // Apply one cycle of stimulus just after the clock edge and queue the
    // outputs expected for that cycle.
    task automatic step(input logic rst, input logic rdy, input logic brt,
                        input logic [31:0] ins, input string nm, input vec_t e);
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = rdy;
        br_taken  = brt;
        instr     = ins;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic fetch_decode(input logic [31:0] ins, input logic brt, input string nm);
        step(1'b0, 1'b1, brt, 32'd0, {nm, "_fetch"}, mk(0,1,0,1,0,0,0,0,0,0,0,0,0));
        step(1'b0, 1'b1, brt, ins,   {nm, "_decode"}, mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    endtask

    initial begin
        // reset held: state FETCH, every strobe low even with mem_ready high
        step(1'b1, 1'b1, 1'b0, 32'd0, "reset_hold", mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
        step(1'b1, 1'b1, 1'b0, 32'd0, "reset_hold2", mk(0,0,0,0,0,0,0,0,0,0,0,0,0));

        // ADDI x1,x0,5
        fetch_decode(32'h00500093, 1'b0, "addi");
        step(0, 1, 0, 32'd0, "addi_exec", mk(2,0,0,0,0,0,1,0,1,0,0,0,0));
        step(0, 1, 0, 32'd0, "addi_wb",   mk(4,0,0,0,1,0,1,0,1,1,0,1,0));

        // LW x2,8(x1) with three wait cycles in MEM
        fetch_decode(32'h0080A103, 1'b0, "lw");
        step(0, 0, 0, 32'd0, "lw_exec",  mk(2,0,0,0,0,0,1,0,1,0,0,0,0));
        step(0, 0, 0, 32'd0, "lw_mem_w1", mk(3,1,0,0,0,0,1,0,1,0,0,0,0));
        step(0, 0, 0, 32'd0, "lw_mem_w2", mk(3,1,0,0,0,0,1,0,1,0,0,0,0));
        step(0, 0, 0, 32'd0, "lw_mem_w3", mk(3,1,0,0,0,0,1,0,1,0,0,0,0));
        step(0, 1, 0, 32'd0, "lw_mem_rdy", mk(3,1,0,0,0,0,1,0,1,0,0,0,0));
        step(0, 1, 0, 32'd0, "lw_wb",    mk(4,0,0,0,1,0,1,0,1,1,1,1,0));

        // BEQ taken / not taken: three cycles, no register write
        fetch_decode(32'h00000463, 1'b1, "beq_t");
        step(0, 1, 1, 32'd0, "beq_t_exec", mk(2,0,0,0,1,1,3,0,0,0,0,1,0));
        fetch_decode(32'h00000463, 1'b0, "beq_n");
        step(0, 1, 0, 32'd0, "beq_n_exec", mk(2,0,0,0,1,0,3,0,0,0,0,1,0));

        // SW x2,4(x1) zero-wait
        fetch_decode(32'h0020A223, 1'b0, "sw");
        step(0, 1, 0, 32'd0, "sw_exec", mk(2,0,0,0,0,0,2,0,1,0,0,0,0));
        step(0, 1, 0, 32'd0, "sw_mem",  mk(3,1,1,0,1,0,2,0,1,0,0,1,0));

        // JAL x1,+16
        fetch_decode(32'h010000EF, 1'b0, "jal");
        step(0, 1, 0, 32'd0, "jal_exec", mk(2,0,0,0,0,0,5,1,1,0,0,0,0));
        step(0, 1, 0, 32'd0, "jal_wb",   mk(4,0,0,0,1,1,5,1,1,1,2,1,0));

        // JALR x0,0(x1): rd is x0, so no register write
        fetch_decode(32'h00008067, 1'b0, "jalr");
        step(0, 1, 0, 32'd0, "jalr_exec", mk(2,0,0,0,0,0,1,0,1,0,0,0,0));
        step(0, 1, 0, 32'd0, "jalr_wb",   mk(4,0,0,0,1,2,1,0,1,0,2,1,0));

        // LUI x5,0x12345
        fetch_decode(32'h123452B7, 1'b0, "lui");
        step(0, 1, 0, 32'd0, "lui_exec", mk(2,0,0,0,0,0,4,2,1,0,0,0,0));
        step(0, 1, 0, 32'd0, "lui_wb",   mk(4,0,0,0,1,0,4,2,1,1,0,1,0));

        // ADD x3,x1,x2
        fetch_decode(32'h002081B3, 1'b0, "add");
        step(0, 1, 0, 32'd0, "add_exec", mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
        step(0, 1, 0, 32'd0, "add_wb",   mk(4,0,0,0,1,0,0,0,0,1,0,1,0));

        // SW interrupted by reset while waiting in MEM
        fetch_decode(32'h0020A223, 1'b0, "sw_rst");
        step(0, 0, 0, 32'd0, "sw_rst_exec", mk(2,0,0,0,0,0,2,0,1,0,0,0,0));
        step(0, 0, 0, 32'd0, "sw_rst_mem",  mk(3,1,1,0,0,0,2,0,1,0,0,0,0));
        step(1, 1, 0, 32'd0, "sw_rst_abort", mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
        step(0, 1, 0, 32'd0, "sw_rst_refetch", mk(0,1,0,1,0,0,0,0,0,0,0,0,0));
        step(0, 1, 0, 32'h00500093, "sw_rst_decode", mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
        step(0, 1, 0, 32'd0, "sw_rst_exec2", mk(2,0,0,0,0,0,1,0,1,0,0,0,0));
        step(0, 1, 0, 32'd0, "sw_rst_wb2",   mk(4,0,0,0,1,0,1,0,1,1,0,1,0));

        // FETCH timeout: four wait cycles then TRAP
        for (int i = 1; i <= 4; i++)
            step(0, 0, 0, 32'd0, $sformatf("fto_wait%0d", i), mk(0,1,0,0,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 32'd0, $sformatf("fto_trap%0d", i), mk(7,0,0,0,0,0,0,0,0,0,0,0,1));
        step(1, 0, 0, 32'd0, "fto_reset", mk(0,0,0,0,0,0,0,0,0,0,0,0,0));

        // mem_ready on the fourth wait cycle wins over the timeout
        for (int i = 1; i <= 3; i++)
            step(0, 0, 0, 32'd0, $sformatf("frdy_wait%0d", i), mk(0,1,0,0,0,0,0,0,0,0,0,0,0));
        step(0, 1, 0, 32'd0, "frdy_ready", mk(0,1,0,1,0,0,0,0,0,0,0,0,0));

        // illegal opcode 0x7F in DECODE -> TRAP, strobes low for 20 cycles
        step(0, 1, 0, 32'h0000007F, "ill_decode", mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 20; i++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h00500093,
                 $sformatf("ill_trap%0d", i), mk(7,0,0,0,0,0,0,0,0,0,0,0,1));

        // MEM timeout on a load
        step(1, 0, 0, 32'd0, "mto_reset", mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
        fetch_decode(32'h0080A103, 1'b0, "mto");
        step(0, 0, 0, 32'd0, "mto_exec", mk(2,0,0,0,0,0,1,0,1,0,0,0,0));
        for (int i = 1; i <= 4; i++)
            step(0, 0, 0, 32'd0, $sformatf("mto_wait%0d", i), mk(3,1,0,0,0,0,1,0,1,0,0,0,0));
        step(0, 1, 0, 32'd0, "mto_trap", mk(7,0,0,0,0,0,0,0,0,0,0,0,1));

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
